// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD front end and digit scanner for the 4-digit FND display.
// A captured 14-bit value is converted with one double-dabble step per clock.
// A free-running divider then steps through the four digits, with optional
// leading-zero blanking applied to the enable.
module fnd_scan_controller #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_blankLz,
    input  logic        i_dispEn,
    output logic [1:0]  o_digitSelect,
    output logic [3:0]  o_bcdValue,
    output logic        o_en,
    output logic        o_busy
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("fnd_scan_controller: CLK_HZ/SCAN_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t      state, state_next;
    logic        load_accept;
    logic        conv_done;
    logic [13:0] value_sat;
    logic [13:0] bin_reg;
    logic [15:0] bcd_reg;
    logic [3:0]  step;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [13:0] bin_shift;
    logic [15:0] disp_reg;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]  digit_cnt;
    logic        scan_tick;
    logic        blank;

    // Values above four decimal digits are shown as 9999.
    assign value_sat = (i_value > 14'd9999) ? 14'd9999 : i_value;

    // State register: idle or converting.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next state: accept a load only when idle; finish after the 14th step.
    always_comb begin
        state_next  = state;
        load_accept = 1'b0;
        conv_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_load) begin
                    load_accept = 1'b1;
                    state_next  = S_CONV;
                end
            end
            S_CONV: begin
                if (step == 4'd13) begin
                    conv_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < 4; i++) begin
            if (bcd_reg[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[14:0], bin_reg[13]};
        bin_shift = {bin_reg[12:0], 1'b0};
    end

    // Conversion working registers and step counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            step    <= '0;
        end else if (load_accept) begin
            bin_reg <= value_sat;
            bcd_reg <= '0;
            step    <= '0;
        end else if (state == S_CONV) begin
            bin_reg <= bin_shift;
            bcd_reg <= bcd_shift;
            step    <= step + 4'd1;
        end
    end

    // Display register takes the finished result on the last step's edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)       disp_reg <= '0;
        else if (conv_done) disp_reg <= bcd_shift;
    end

    assign scan_tick = (div_cnt == DIV_LAST);

    // Free-running scan divider and digit counter, independent of conversion.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            div_cnt   <= '0;
            digit_cnt <= '0;
        end else if (scan_tick) begin
            div_cnt   <= '0;
            digit_cnt <= digit_cnt + 2'd1;
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // Leading-zero blanking for the digit currently selected.
    always_comb begin
        blank = 1'b0;
        if (i_blankLz) begin
            case (digit_cnt)
                2'd3: blank = (disp_reg[15:12] == 4'd0);
                2'd2: blank = (disp_reg[15:8] == 8'd0);
                2'd1: blank = (disp_reg[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    assign o_digitSelect = digit_cnt;
    assign o_bcdValue    = disp_reg[{digit_cnt, 2'b00} +: 4];
    assign o_en          = i_dispEn & ~blank;
    assign o_busy        = (state == S_CONV);

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with DIV=4.
// Expected displays are queued when a load is driven and popped when busy drops.
module tb_fnd_scan_controller;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        blank_lz;
    logic        disp_en;
    logic [1:0]  digit_select;
    logic [3:0]  bcd_value;
    logic        en;
    logic        busy;

    fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(250)) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_value(value),
        .i_load(load),
        .i_blankLz(blank_lz),
        .i_dispEn(disp_en),
        .o_digitSelect(digit_select),
        .o_bcdValue(bcd_value),
        .o_en(en),
        .o_busy(busy)
    );

    typedef struct {
        logic [13:0] value;
        logic        blank_lz;
        logic        disp_en;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_mask;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  mask;
    } sb_entry_t;

    vec_t        vectors[12];
    sb_entry_t   sb[$];
    sb_entry_t   popped;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cur_disp;
    logic [3:0]  cur_mask;
    logic [1:0]  model_div;
    logic [1:0]  model_dig;

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scan counter: digit advances every 4 clocks after reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_div <= 2'd0;
            model_dig <= 2'd0;
        end else if (model_div == 2'd3) begin
            model_div <= 2'd0;
            model_dig <= model_dig + 2'd1;
        end else begin
            model_div <= model_div + 2'd1;
        end
    end

    function automatic logic [3:0] visMask(input logic [15:0] d, input logic blz);
        logic [3:0] m;
        if (!blz) return 4'hF;
        m[0] = 1'b1;
        m[1] = (d[15:4] != 12'd0);
        m[2] = (d[15:8] != 8'd0);
        m[3] = (d[15:12] != 4'd0);
        return m;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare select, nibble and enable at the current sample point.
    task automatic checkOutput();
        check("select", {14'd0, digit_select}, {14'd0, model_dig});
        check("bcd", {12'd0, bcd_value}, {12'd0, cur_disp[{model_dig, 2'b00} +: 4]});
        check("en", {15'd0, en}, {15'd0, disp_en & cur_mask[model_dig]});
        check("busy_idle", {15'd0, busy}, 16'd0);
    endtask

    task automatic scanSweep(input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput();
            @(negedge clk);
        end
    endtask

    // Drive a one-cycle load and queue the result it should produce.
    task automatic applyStimulus(input logic [13:0] v, input logic blz, input logic den,
                                 input logic [15:0] exp_bcd, input logic [3:0] exp_mask);
        sb_entry_t e;
        blank_lz = blz;
        disp_en  = den;
        value    = v;
        load     = 1'b1;
        e.bcd    = exp_bcd;
        e.mask   = exp_mask;
        sb.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Count busy cycles, optionally inject an ignored load or a reset.
    task automatic waitDone(input int ignore_at, input int reset_at);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            check("busy_select", {14'd0, digit_select}, {14'd0, model_dig});
            check("busy_bcd", {12'd0, bcd_value}, {12'd0, cur_disp[{model_dig, 2'b00} +: 4]});
            if (cnt == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", {15'd0, busy}, 16'd0);
                check("abort_select", {14'd0, digit_select}, 16'd0);
                check("abort_bcd", {12'd0, bcd_value}, 16'd0);
                sb.delete();
                cur_disp = 16'h0000;
                cur_mask = visMask(16'h0000, blank_lz);
                load = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cnt == ignore_at) begin
                value = 14'd1111;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("busy_len", cnt[15:0], 16'd14);
        if (sb.size() == 0) begin
            check("sb_nonempty", 16'd0, 16'd1);
        end else begin
            popped   = sb.pop_front();
            cur_disp = popped.bcd;
            cur_mask = popped.mask;
        end
    endtask

    initial begin
        vectors[0]  = '{14'd1234,  1'b0, 1'b1, 16'h1234, 4'b1111};
        vectors[1]  = '{14'd12000, 1'b0, 1'b1, 16'h9999, 4'b1111};
        vectors[2]  = '{14'd16383, 1'b0, 1'b1, 16'h9999, 4'b1111};
        vectors[3]  = '{14'd9999,  1'b0, 1'b1, 16'h9999, 4'b1111};
        vectors[4]  = '{14'd70,    1'b1, 1'b1, 16'h0070, 4'b0011};
        vectors[5]  = '{14'd0,     1'b1, 1'b1, 16'h0000, 4'b0001};
        vectors[6]  = '{14'd5,     1'b1, 1'b1, 16'h0005, 4'b0001};
        vectors[7]  = '{14'd100,   1'b1, 1'b1, 16'h0100, 4'b0111};
        vectors[8]  = '{14'd1001,  1'b1, 1'b1, 16'h1001, 4'b1111};
        vectors[9]  = '{14'd0,     1'b0, 1'b1, 16'h0000, 4'b1111};
        vectors[10] = '{14'd4321,  1'b0, 1'b0, 16'h4321, 4'b1111};
        vectors[11] = '{14'd10000, 1'b0, 1'b1, 16'h9999, 4'b1111};

        rst_n    = 1'b0;
        value    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        disp_en  = 1'b1;
        cur_disp = 16'h0000;
        cur_mask = 4'hF;

        #3;
        check("reset_select", {14'd0, digit_select}, 16'd0);
        check("reset_bcd", {12'd0, bcd_value}, 16'd0);
        check("reset_en", {15'd0, en}, 16'd1);
        check("reset_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scanSweep(20);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vectors[i].value, vectors[i].blank_lz, vectors[i].disp_en,
                          vectors[i].exp_bcd, vectors[i].exp_mask);
            waitDone(0, 0);
            scanSweep(16);
        end

        // Load during busy is dropped.
        applyStimulus(14'd5678, 1'b0, 1'b1, 16'h5678, 4'hF);
        waitDone(5, 0);
        scanSweep(16);

        // Reset mid-conversion clears the display.
        applyStimulus(14'd5678, 1'b0, 1'b1, 16'h5678, 4'hF);
        waitDone(0, 7);
        scanSweep(16);

        // Back-to-back: second load in the first idle cycle.
        applyStimulus(14'd4321, 1'b0, 1'b1, 16'h4321, 4'hF);
        waitDone(0, 0);
        applyStimulus(14'd9, 1'b0, 1'b1, 16'h0009, 4'hF);
        waitDone(0, 0);
        scanSweep(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
